// File: rtl/mips_ctrl_pkg.sv
// Shared constants, control-word struct and state encoding for the multi-cycle MIPS controller.
// ADDI_EN adds the two ADDI states to the state encoding.
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP
`ifdef ADDI_EN
    , S_ADDIEXEC, S_ADDIWB
`endif
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation; unknown funct flags illegal and falls back to add.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl,
  output logic       o_illegal
);
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_illegal  = 1'b0;
    case (i_funct)
      FN_ADD:  o_alu_ctrl = ALU_ADD;
      FN_SUB:  o_alu_ctrl = ALU_SUB;
      FN_AND:  o_alu_ctrl = ALU_AND;
      FN_OR:   o_alu_ctrl = ALU_OR;
      FN_SLT:  o_alu_ctrl = ALU_SLT;
      default: o_illegal  = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the shared-memory MIPS-subset datapath.
// Define ADDI_EN to support addi (opcode 001000); otherwise it decodes as illegal.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       IllegalOp
);
  state_t     r_state;
  state_t     w_next;
  ctrl_t      w_ctrl;
  ctrl_t      w_out;
  logic [2:0] w_fn_alu;
  logic       w_fn_illegal;

  alu_decoder u_alu_dec (
    .i_funct    (funct),
    .o_alu_ctrl (w_fn_alu),
    .o_illegal  (w_fn_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_4;
        w_ctrl.alu_ctrl  = ALU_ADD;
        w_ctrl.pc_src    = PCSRC_ALU;
        // PC+4 and IR load land together on the cycle memory completes
        w_ctrl.ir_write  = MemReady;
        w_ctrl.pc_en     = MemReady;
        if (MemReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_ctrl.alu_src_b = SRCB_IMM2;
        w_ctrl.alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
`ifdef ADDI_EN
          OP_ADDI:      w_next = S_ADDIEXEC;
`endif
          default: begin
            w_ctrl.illegal = 1'b1;
            w_next         = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_B;
        w_ctrl.alu_ctrl  = w_fn_alu;
        w_ctrl.illegal   = w_fn_illegal;
        w_next           = w_fn_illegal ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_next           = S_FETCH;
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_ctrl  = ALU_ADD;
        w_next           = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_ctrl.iord     = 1'b1;
        w_ctrl.mem_read = 1'b1;
        if (MemReady) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_next            = S_FETCH;
      end
      S_MEMWR: begin
        w_ctrl.iord      = 1'b1;
        w_ctrl.mem_write = 1'b1;
        if (MemReady) w_next = S_FETCH;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_B;
        w_ctrl.alu_ctrl  = ALU_SUB;
        w_ctrl.pc_src    = PCSRC_ALUOUT;
        w_ctrl.pc_en     = (opcode == OP_BEQ) ? Zero : ~Zero;
        w_next           = S_FETCH;
      end
      S_JUMP: begin
        w_ctrl.pc_src = PCSRC_JUMP;
        w_ctrl.pc_en  = 1'b1;
        w_next        = S_FETCH;
      end
`ifdef ADDI_EN
      S_ADDIEXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_ctrl  = ALU_ADD;
        w_next           = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_ctrl.reg_write = 1'b1;
        w_next           = S_FETCH;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

  // Outputs are forced quiet while reset is held, even though the state reads FETCH.
  assign w_out = rst_n ? w_ctrl : '0;

  assign PCEn       = w_out.pc_en;
  assign IorD       = w_out.iord;
  assign MemRead    = w_out.mem_read;
  assign MemWrite   = w_out.mem_write;
  assign IRWrite    = w_out.ir_write;
  assign RegDst     = w_out.reg_dst;
  assign MemToReg   = w_out.mem_to_reg;
  assign RegWrite   = w_out.reg_write;
  assign ALUSrcA    = w_out.alu_src_a;
  assign ALUSrcB    = w_out.alu_src_b;
  assign ALUControl = w_out.alu_ctrl;
  assign PCSrc      = w_out.pc_src;
  assign IllegalOp  = w_out.illegal;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control words queued by stimulus,
// checked by an independent negedge monitor.
module tb_multicycle_control;
  typedef logic [16:0] vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .Zero(Zero), .MemReady(MemReady),
    .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  vec_t  act;
  assign act = {PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
                ALUSrcA, ALUSrcB, ALUControl, PCSrc, IllegalOp};

  vec_t  exp_q[$];
  string name_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    fetch_w = -1;   // -1: random MemReady, else number of low cycles before ready
  int    mem_w = -1;
  int    zero_cfg = -1;  // -1: random Zero in BRANCH

  // monitor
  vec_t  m_e;
  string m_nm;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e  = exp_q.pop_front();
      m_nm = name_q.pop_front();
      n_chk++;
      if (act !== m_e) begin
        n_fail++;
        $display("FAIL %s @%0t: got %b expected %b", m_nm, $time, act, m_e);
      end
      n_chk++;
      if (MemRead && MemWrite) begin
        n_fail++;
        $display("FAIL mem_exclusive %s: got MemRead=1 MemWrite=1 expected at most one", m_nm);
      end
    end
  end

  function automatic vec_t mk(input bit pcen, iord, mrd, mwr, irw, rdst, m2r, rw, asa,
                              input bit [1:0] asb, input bit [2:0] aluc,
                              input bit [1:0] pcs, input bit ill);
    return {pcen, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aluc, pcs, ill};
  endfunction

  function automatic bit [3:0] alu_ref(input bit [5:0] fn);
    case (fn)
      6'h20:   return {3'b010, 1'b0};
      6'h22:   return {3'b110, 1'b0};
      6'h24:   return {3'b000, 1'b0};
      6'h25:   return {3'b001, 1'b0};
      6'h2a:   return {3'b111, 1'b0};
      default: return {3'b010, 1'b1};
    endcase
  endfunction

  function automatic bit op_legal(input bit [5:0] op);
    if (op == 6'h00 || op == 6'h23 || op == 6'h2b || op == 6'h04 || op == 6'h05 || op == 6'h02)
      return 1'b1;
`ifdef ADDI_EN
    if (op == 6'h08) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic bit ready(inout int w, input int cfg);
    if (cfg < 0) return ($urandom_range(0, 3) != 0);
    if (w > 0) begin
      w--;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input vec_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_in();
    MemReady = 1'($urandom_range(0, 1));
    Zero     = 1'($urandom_range(0, 1));
  endtask

  task automatic fetch_phase();
    int w = fetch_w;
    bit r;
    do begin
      r = ready(w, fetch_w);
      MemReady = r;
      Zero = 1'($urandom_range(0, 1));
      step(mk(r, 0, 1, 0, r, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0), "fetch");
    end while (!r);
  endtask

  task automatic mem_phase(input bit wr, input string nm);
    int w = mem_w;
    bit r;
    do begin
      r = ready(w, mem_w);
      MemReady = r;
      step(mk(0, 1, !wr, wr, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0), nm);
    end while (!r);
  endtask

  task automatic run_instr(input bit [5:0] op, input bit [5:0] fn);
    bit [3:0] af;
    bit       z;
    opcode = op;
    funct  = fn;
    fetch_phase();
    rnd_in();
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, !op_legal(op)), "decode");
    if (!op_legal(op)) return;
    case (op)
      6'h00: begin
        af = alu_ref(fn);
        rnd_in();
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, af[3:1], 2'b00, af[0]), "exec");
        if (!af[0]) begin
          rnd_in();
          step(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0), "aluwb");
        end
      end
      6'h23, 6'h2b: begin
        rnd_in();
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0), "memadr");
        if (op == 6'h2b) mem_phase(1'b1, "memwr");
        else begin
          mem_phase(1'b0, "memrd");
          rnd_in();
          step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0), "memwb");
        end
      end
      6'h04, 6'h05: begin
        rnd_in();
        z = (zero_cfg < 0) ? 1'($urandom_range(0, 1)) : 1'(zero_cfg);
        Zero = z;
        step(mk((op == 6'h04) ? z : !z, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0), "branch");
      end
      6'h02: begin
        rnd_in();
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0), "jump");
      end
      default: begin
        rnd_in();
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0), "addiexec");
        rnd_in();
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0), "addiwb");
      end
    endcase
  endtask

  task automatic reset_in_memwr();
    opcode = 6'h2b;
    funct  = 6'($urandom);
    fetch_phase();
    rnd_in();
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0), "decode_sw");
    rnd_in();
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0), "memadr_sw");
    MemReady = 1'b0;
    step(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0), "memwr_wait");
    rst_n = 1'b0;
    MemReady = 1'b1;
    step('0, "reset_mid_memwr");
    step('0, "reset_held");
    rst_n = 1'b1;
    run_instr(6'h00, 6'h20);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit [5:0] ops[8];
    bit [5:0] fns[6];
    @(posedge clk);
    #1;
    MemReady = 1'b1;
    step('0, "reset_state");
    step('0, "reset_state_hold");
    rst_n = 1'b1;

    fetch_w = 0; mem_w = 0;
    run_instr(6'h00, 6'h20);               // add, 4 cycles
    mem_w = 2;
    run_instr(6'h23, 6'h00);               // lw, 2 wait cycles in MEMRD
    mem_w = 0;
    zero_cfg = 1; run_instr(6'h04, 6'h00);
    zero_cfg = 0; run_instr(6'h04, 6'h00);
    zero_cfg = 1; run_instr(6'h05, 6'h00);
    zero_cfg = 0; run_instr(6'h05, 6'h00);
    zero_cfg = -1;
    run_instr(6'h3f, 6'h20);               // illegal opcode
    run_instr(6'h00, 6'h3f);               // illegal funct
    run_instr(6'h08, 6'h00);               // addi
    run_instr(6'h2b, 6'h00);               // sw
    run_instr(6'h02, 6'h00);               // j
    mem_w = 3;
    run_instr(6'h2b, 6'h00);
    reset_in_memwr();

    fetch_w = -1; mem_w = -1;
    for (int i = 0; i < 200; i++) begin
      ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'($urandom)};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'($urandom)};
      run_instr(ops[$urandom_range(0, 7)], fns[$urandom_range(0, 5)]);
    end

    repeat (3) @(posedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
